thread_switch_controller: RTL
=============================

Name: thread_switch_controller

Overview:
Drives the thread-control inputs of the fetch stage for two-thread coarse-grained multithreading. It owns the current thread id and the per-thread resume PCs. It decides when to switch: on a long-latency miss (immediate) or on quantum expiry (time-slice). It stalls the front end when both threads are blocked, and redirects fetch when the current thread unblocks first.

Parameters:
ADDR_WIDTH, 26, byte-address width; MSB of every PC equals the owning thread id.
QUANTUM, 64, cycles a thread may run before a time-slice switch (>=2).
QCNT_W, 8, width of quantum counter (must hold QUANTUM-1).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_stall  in  1  pipeline hazard stall (freezes quantum counter)
i_pc_current  in  ADDR_WIDTH  fetch stage current PC
i_miss_req  in  1  current thread hit long-latency miss; one-cycle pulse
i_miss_pc  in  ADDR_WIDTH  PC to replay for the missing instruction
i_miss_done  in  1  outstanding miss of a thread resolved; one-cycle pulse
i_miss_done_tid  in  1  thread whose miss resolved
o_thread_switch  out  1  one-cycle switch pulse to fetch
o_thread_id  out  1  current thread id
o_thread_resume_pc_0  out  ADDR_WIDTH  resume PC of thread 0
o_thread_resume_pc_1  out  ADDR_WIDTH  resume PC of thread 1
o_stall_req  out  1  hold front end (both threads blocked)
o_load_we  out  1  one-cycle fetch redirect, same thread
o_load_pc  out  ADDR_WIDTH  redirect target

Behaviour:
- Reset (rst high at posedge, any state): state RUN; o_thread_id=0; resume_pc_0=0x0000000; resume_pc_1={1'b1,25'b0}=0x2000000; blocked[1:0]=0; qcnt=0; all pulse outputs and o_stall_req =0.
- Reset applied mid-WAIT or mid-SWITCH abandons the switch; no pulse is emitted that cycle.
- Outputs are registered; decisions take effect the cycle after the triggering input.
- State RUN:
  - qcnt increments each cycle with i_stall=0; holds while i_stall=1.
  - On i_miss_req: resume_pc[tid] <= i_miss_pc; blocked[tid] <= 1.
    - If other thread not blocked: go SWITCH.
    - Else: go WAIT.
  - Else if qcnt==QUANTUM-1, i_stall=0 and other thread not blocked: resume_pc[tid] <= i_pc_current; go SWITCH.
  - Quantum expiry with other thread blocked: qcnt wraps to 0, no switch.
  - i_miss_req outranks simultaneous quantum expiry.
- State SWITCH (exactly one cycle):
  - o_thread_switch=1 while o_thread_id still shows the old thread, so fetch loads resume_pc[~tid].
  - Next cycle: o_thread_id toggles; qcnt=0; state RUN.
  - i_miss_req during SWITCH is dropped (pipeline being flushed).
- State WAIT: o_stall_req=1; qcnt held at 0.
  - i_miss_done for the other thread: clear its blocked bit; go SWITCH (o_stall_req drops the same cycle o_thread_switch rises).
  - i_miss_done for the current thread: clear its blocked bit; o_load_we=1 for one cycle with o_load_pc=resume_pc[tid]; go RUN.
- i_miss_done in any state clears blocked[i_miss_done_tid]; same-cycle set (miss_req) and clear of the same bit: set wins.
- o_thread_switch and o_load_we are never high together and never high two consecutive cycles.
- Resume PC MSB is forced to its thread id on every write: bits [ADDR_WIDTH-2:0] come from the source, and the MSB equals the thread index.

Test Plan:
- Reset check: after rst, outputs are id=0, resume_pc_0=0x0, resume_pc_1=0x2000000, switch=0, stall_req=0.
- Quantum switch: QUANTUM=8, no stalls, i_pc_current=0x0000020 at cycle 7 after reset -> switch pulse at cycle 8 with id=0; resume_pc_0=0x20; id=1 at cycle 9.
- Stall freeze: i_stall=1 for 5 cycles mid-quantum -> switch pulse delayed by exactly 5 cycles.
- Miss switch: i_miss_req with i_miss_pc=0x0000104 on thread 0 -> next cycle switch pulse; resume_pc_0=0x104; blocked[0]=1; later quantum expiry on thread 1 produces no switch.
- Both blocked: thread 1 misses (pc 0x2000040) while thread 0 blocked -> WAIT with stall_req=1.
  - i_miss_done tid=0 -> switch pulse, id becomes 0.
  - Alternatively i_miss_done tid=1 -> o_load_we=1, o_load_pc=0x2000040, id stays 1.
- Simultaneous: i_miss_req in the qcnt==QUANTUM-1 cycle -> resume PC = i_miss_pc (not i_pc_current), single switch pulse.
- rst in WAIT -> state RUN, blocked=0, no switch or load pulse.

Source files
------------

// File: rtl/thread_switch_controller.sv
// thread_switch_controller: two-thread coarse-grained switch control for fetch (miss and quantum switching, stall, redirect)
module thread_switch_controller #(
  parameter int ADDR_WIDTH = 26,
  parameter int QUANTUM = 64,
  parameter int QCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic [ADDR_WIDTH-1:0] i_pc_current,
  input  logic                  i_miss_req,
  input  logic [ADDR_WIDTH-1:0] i_miss_pc,
  input  logic                  i_miss_done,
  input  logic                  i_miss_done_tid,
  output logic                  o_thread_switch,
  output logic                  o_thread_id,
  output logic [ADDR_WIDTH-1:0] o_thread_resume_pc_0,
  output logic [ADDR_WIDTH-1:0] o_thread_resume_pc_1,
  output logic                  o_stall_req,
  output logic                  o_load_we,
  output logic [ADDR_WIDTH-1:0] o_load_pc
);
  typedef enum logic [1:0] {RUN, SWITCH, WAIT} state_t;
  state_t state;
  logic [1:0] blocked;
  logic [QCNT_W-1:0] qcnt;
  logic [1:0] clr;
  logic [1:0] blk_eff;
  logic oth;
  logic expire;
  logic wr_en;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] wr_pc;
  logic [ADDR_WIDTH-1:0] cur_pc;
  localparam logic [ADDR_WIDTH-1:0] MSB = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
  assign clr = {i_miss_done & i_miss_done_tid, i_miss_done & ~i_miss_done_tid};
  assign blk_eff = blocked & ~clr;
  assign oth = ~o_thread_id;
  assign expire = qcnt == QCNT_W'(QUANTUM - 1) && !i_stall;
  assign wr_en = state == RUN && (i_miss_req || (expire && !blk_eff[oth]));
  assign src = i_miss_req ? i_miss_pc : i_pc_current;
  assign wr_pc = (src | MSB) & {o_thread_id, {(ADDR_WIDTH-1){1'b1}}};
  assign cur_pc = o_thread_id ? o_thread_resume_pc_1 : o_thread_resume_pc_0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      o_thread_id <= 1'b0;
      o_thread_resume_pc_0 <= '0;
      o_thread_resume_pc_1 <= MSB;
      blocked <= 2'b00;
      qcnt <= '0;
      o_thread_switch <= 1'b0;
      o_stall_req <= 1'b0;
      o_load_we <= 1'b0;
      o_load_pc <= '0;
    end else begin
      o_thread_switch <= 1'b0;
      o_load_we <= 1'b0;
      blocked <= blk_eff;
      if (wr_en && o_thread_id) o_thread_resume_pc_1 <= wr_pc;
      if (wr_en && !o_thread_id) o_thread_resume_pc_0 <= wr_pc;
      case (state)
        RUN: begin
          if (i_miss_req) begin
            blocked[o_thread_id] <= 1'b1;
            qcnt <= '0;
            state <= blk_eff[oth] ? WAIT : SWITCH;
            o_stall_req <= blk_eff[oth];
            o_thread_switch <= !blk_eff[oth];
          end else if (expire) begin
            qcnt <= '0;
            state <= blk_eff[oth] ? RUN : SWITCH;
            o_thread_switch <= !blk_eff[oth];
          end else if (!i_stall) begin
            qcnt <= qcnt + 1'b1;
          end
        end
        SWITCH: begin
          state <= RUN;
          o_thread_id <= oth;
          qcnt <= '0;
        end
        WAIT: begin
          if (i_miss_done) begin
            o_stall_req <= 1'b0;
            state <= i_miss_done_tid == o_thread_id ? RUN : SWITCH;
            o_thread_switch <= i_miss_done_tid != o_thread_id;
            o_load_we <= i_miss_done_tid == o_thread_id;
            o_load_pc <= cur_pc;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
